// File: rtl/crc16_rx_check.sv
// Receive-side CRC-16/X-25 checker: strips the trailing 16 CRC bits from a serial
// frame, forwards the payload and reports a per-frame verdict with saturating counters.

module crc16_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end
endmodule

module crc16_rx_check #(
    parameter logic [15:0] INIT  = 16'hFFFF,
    parameter int          CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_in_valid,
    output logic             data_out,
    output logic             data_out_valid,
    output logic             frame_done,
    output logic             crc_ok,
    output logic             crc_err,
    output logic             short_frame,
    output logic [CNT_W-1:0] ok_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [15:0] POLY = 16'h8408;
    localparam logic [4:0]  FULL = 5'd16;

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state_q, state_d;
    logic [15:0] dl_q;
    logic [15:0] lfsr_q;
    logic [4:0]  fill_q;
    logic        accept, end_cyc;
    logic        full, fb, match;
    logic [15:0] lfsr_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        end_cyc = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_in_valid) begin
                    accept  = 1'b1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (data_in_valid) begin
                    accept = 1'b1;
                end else begin
                    end_cyc = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Once the delay line holds 16 bits, the bit falling out of dl[0] can no longer
    // be part of the CRC field, so it is payload: feed it to the LFSR and forward it.
    assign full      = (fill_q == FULL);
    assign fb        = lfsr_q[0] ^ dl_q[0];
    assign lfsr_step = {1'b0, lfsr_q[15:1]} ^ (fb ? POLY : 16'h0000);
    // The CRC goes out inverted and LSB first, so dl[k] lines up with ~lfsr[k].
    assign match     = full && (dl_q == ~lfsr_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q           <= '0;
            lfsr_q         <= INIT;
            fill_q         <= '0;
            data_out       <= 1'b0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            crc_ok         <= 1'b0;
            crc_err        <= 1'b0;
            short_frame    <= 1'b0;
        end else begin
            data_out       <= 1'b0;
            data_out_valid <= 1'b0;
            frame_done     <= 1'b0;
            crc_ok         <= 1'b0;
            crc_err        <= 1'b0;
            short_frame    <= 1'b0;
            if (accept) begin
                dl_q <= {data_in, dl_q[15:1]};
                if (!full) begin
                    fill_q <= fill_q + 1'b1;
                end else begin
                    lfsr_q         <= lfsr_step;
                    data_out       <= dl_q[0];
                    data_out_valid <= 1'b1;
                end
            end else if (end_cyc) begin
                frame_done  <= 1'b1;
                short_frame <= !full;
                crc_ok      <= match;
                crc_err     <= !match;
                lfsr_q      <= INIT;
                fill_q      <= '0;
                dl_q        <= '0;
            end
        end
    end

    crc16_sat_cnt #(.W(CNT_W)) u_ok_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (end_cyc && match),
        .cnt   (ok_cnt)
    );

    crc16_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (end_cyc && !match),
        .cnt   (err_cnt)
    );
endmodule

// File: tb/tb_crc16_rx_check.sv
// Directed bench for crc16_rx_check: known X-25 frames, corrupted, short,
// back-to-back, reset-aborted and counter-saturation cases.

module tb_crc16_rx_check;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       data_in = 1'b0;
    logic       data_in_valid = 1'b0;
    logic       data_out, data_out_valid, frame_done, crc_ok, crc_err, short_frame;
    logic [7:0] ok_cnt, err_cnt;

    int compared = 0;
    int mismatched = 0;
    logic rx_q[$];

    // "123456789" LSB first per byte, followed by CRC 0x906E LSB first
    localparam logic [87:0] GOOD = 88'h906E_393837363534333231;
    localparam logic [87:0] BAD  = GOOD ^ 88'h20;

    crc16_rx_check #(.INIT(16'hFFFF), .CNT_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .frame_done     (frame_done),
        .crc_ok         (crc_ok),
        .crc_err        (crc_err),
        .short_frame    (short_frame),
        .ok_cnt         (ok_cnt),
        .err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (data_out_valid) rx_q.push_back(data_out);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [127:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            data_in       = bits[i];
            data_in_valid = 1'b1;
        end
    endtask

    // Drop valid for the end cycle, then land on the cycle carrying the verdict.
    task automatic end_frame();
        @(negedge clk);
        data_in_valid = 1'b0;
        data_in       = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_verdict(input string tag, input logic ok, input logic shrt);
        check({tag, "_done"},  frame_done,  1'b1);
        check({tag, "_ok"},    crc_ok,      ok);
        check({tag, "_err"},   crc_err,     !ok);
        check({tag, "_short"}, short_frame, shrt);
    endtask

    task automatic check_payload(input string tag, input logic [127:0] exp, input int n);
        logic [127:0] got;
        got = '0;
        check({tag, "_len"}, rx_q.size(), n);
        for (int i = 0; i < rx_q.size() && i < 128; i++) got[i] = rx_q[i];
        check({tag, "_bits"}, got, exp);
    endtask

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset_outs", {data_out, data_out_valid, frame_done, crc_ok, crc_err, short_frame}, 6'b0);
        check("reset_cnts", {ok_cnt, err_cnt}, 16'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Reference frame
        rx_q.delete();
        send(128'(GOOD), 88);
        end_frame();
        check_verdict("good", 1'b1, 1'b0);
        check("good_okcnt", ok_cnt, 8'd1);
        check_payload("good_pl", 128'(GOOD[71:0]), 72);
        @(negedge clk);
        check("good_pulse", {frame_done, crc_ok}, 2'b00);

        // Payload bit 5 flipped
        rx_q.delete();
        send(128'(BAD), 88);
        end_frame();
        check_verdict("bad", 1'b0, 1'b0);
        check("bad_errcnt", err_cnt, 8'd1);
        check_payload("bad_pl", 128'(BAD[71:0]), 72);

        // Empty payload: all-zero CRC is correct
        rx_q.delete();
        send(128'h0, 16);
        end_frame();
        check_verdict("zeros", 1'b1, 1'b0);
        check("zeros_dov", rx_q.size(), 0);
        check("zeros_okcnt", ok_cnt, 8'd2);

        send(128'hFFFF, 16);
        end_frame();
        check_verdict("ones", 1'b0, 1'b0);
        check("ones_errcnt", err_cnt, 8'd2);

        // Short frame
        rx_q.delete();
        send(128'h2A5, 10);
        end_frame();
        check_verdict("short", 1'b0, 1'b1);
        check("short_dov", rx_q.size(), 0);
        check("short_errcnt", err_cnt, 8'd3);

        // Back-to-back: second frame's first bit right after the end cycle
        send(128'(GOOD), 88);
        end_frame();
        check_verdict("b2b_1", 1'b1, 1'b0);
        rx_q.delete();
        data_in       = GOOD[0];
        data_in_valid = 1'b1;
        send(128'(GOOD >> 1), 87);
        end_frame();
        check_verdict("b2b_2", 1'b1, 1'b0);
        check_payload("b2b_pl", 128'(GOOD[71:0]), 72);
        check("b2b_okcnt", ok_cnt, 8'd4);

        // Reset mid-frame
        send(128'(GOOD), 40);
        @(negedge clk);
        data_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_cnts", {ok_cnt, err_cnt}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_noverdict", frame_done, 1'b0);
        rx_q.delete();
        send(128'(GOOD), 88);
        end_frame();
        check_verdict("after_rst", 1'b1, 1'b0);
        check("after_rst_cnt", {ok_cnt, err_cnt}, {8'd1, 8'd0});
        check_payload("after_rst_pl", 128'(GOOD[71:0]), 72);

        // Error counter saturation with 300 one-bit frames
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            data_in       = 1'b1;
            data_in_valid = 1'b1;
            @(negedge clk);
            data_in_valid = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        check("sat_errcnt", err_cnt, 8'd255);
        check("sat_okcnt", ok_cnt, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
